// File: rtl/servo_slew.sv
// APB3 servo slew limiter: walks yaw/pitch duties toward software targets
// by a programmable step once per tick, feeding PWM compare values.
module servo_slew #(
    parameter int unsigned TICK_DIV   = 100000,
    parameter int unsigned DUTY_MIN   = 100000,
    parameter int unsigned DUTY_MAX   = 200000,
    parameter int unsigned DUTY_RESET = 150000,
    parameter int unsigned STEP_RESET = 100
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [31:0] yaw_duty,
    output logic [31:0] pitch_duty,
    output logic        duty_valid,
    output logic [1:0]  busy
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] L_LAST = CW'(TICK_DIV - 1);
    localparam logic [31:0] L_MIN = 32'(DUTY_MIN);
    localparam logic [31:0] L_MAX = 32'(DUTY_MAX);
    localparam logic [31:0] L_RST = 32'(DUTY_RESET);
    localparam logic [31:0] L_STP = 32'(STEP_RESET);

    logic [31:0]   r_tgt_yaw;
    logic [31:0]   r_tgt_pitch;
    logic [31:0]   r_step;
    logic          r_enable;
    logic          r_snap;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_yaw;
    logic [31:0]   r_pitch;
    logic [31:0]   r_prdata;
    logic          r_dv;

    logic          w_wr;
    logic          w_rd;
    logic          w_mapped;
    logic          w_tick;
    logic [31:0]   w_rdata;
    logic [31:0]   w_yaw_nxt;
    logic [31:0]   w_pitch_nxt;
    logic [1:0]    w_busy;
    logic          w_unused_bits;

    // Move cur toward tgt by at most step; difference first so no wrap.
    function automatic logic [31:0] f_walk(
        input logic [31:0] cur,
        input logic [31:0] tgt,
        input logic [31:0] step
    );
        logic [31:0] d;
        logic [31:0] inc;
        d   = (cur < tgt) ? (tgt - cur) : (cur - tgt);
        inc = (step < d) ? step : d;
        return (cur < tgt) ? (cur + inc) : (cur - inc);
    endfunction

    // Targets are held inside the legal servo pulse window.
    function automatic logic [31:0] f_clamp(input logic [31:0] v);
        if (v < L_MIN) return L_MIN;
        if (v > L_MAX) return L_MAX;
        return v;
    endfunction

    assign w_wr   = PSEL & PENABLE & PWRITE;
    assign w_rd   = PSEL & ~PENABLE & ~PWRITE;
    assign w_tick = r_enable & (r_cnt == L_LAST);
    assign w_busy = {r_pitch != r_tgt_pitch, r_yaw != r_tgt_yaw};
    assign w_unused_bits = ^PADDR[31:8];

    assign PRDATA     = r_prdata;
    assign PREADY     = 1'b1;
    assign PSLVERR    = PSEL & PENABLE & ~w_mapped;
    assign yaw_duty   = r_yaw;
    assign pitch_duty = r_pitch;
    assign duty_valid = r_dv;
    assign busy       = w_busy;

    // Address decode and read-data mux from registered state.
    always_comb begin
        w_mapped = 1'b1;
        w_rdata  = '0;
        case (PADDR[7:0])
            8'h00: w_rdata = r_tgt_yaw;
            8'h04: w_rdata = r_tgt_pitch;
            8'h08: w_rdata = r_step;
            8'h0C: w_rdata = {22'd0, w_busy, 7'd0, r_enable};
            8'h10: w_rdata = r_yaw;
            8'h14: w_rdata = r_pitch;
            default: begin
                w_mapped = 1'b0;
                w_rdata  = '0;
            end
        endcase
    end

    // Next current duties: snap beats step==0 tracking beats tick walk.
    always_comb begin
        w_yaw_nxt   = r_yaw;
        w_pitch_nxt = r_pitch;
        if (r_snap || (r_enable && r_step == '0)) begin
            w_yaw_nxt   = r_tgt_yaw;
            w_pitch_nxt = r_tgt_pitch;
        end else if (w_tick) begin
            w_yaw_nxt   = f_walk(r_yaw, r_tgt_yaw, r_step);
            w_pitch_nxt = f_walk(r_pitch, r_tgt_pitch, r_step);
        end
    end

    // APB register writes and registered read data.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_tgt_yaw   <= L_RST;
            r_tgt_pitch <= L_RST;
            r_step      <= L_STP;
            r_enable    <= 1'b1;
            r_snap      <= 1'b0;
            r_prdata    <= '0;
        end else begin
            r_snap <= 1'b0;
            if (w_rd) begin
                r_prdata <= w_rdata;
            end
            if (w_wr) begin
                case (PADDR[7:0])
                    8'h00: r_tgt_yaw   <= f_clamp(PWDATA);
                    8'h04: r_tgt_pitch <= f_clamp(PWDATA);
                    8'h08: r_step      <= PWDATA;
                    8'h0C: begin
                        r_enable <= PWDATA[0];
                        r_snap   <= PWDATA[1];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Tick prescaler, parked at zero while disabled.
    always_ff @(posedge PCLK) begin
        if (PRESET || !r_enable || r_cnt == L_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Current duties and the change strobe that follows them.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_yaw   <= L_RST;
            r_pitch <= L_RST;
            r_dv    <= 1'b0;
        end else begin
            r_yaw   <= w_yaw_nxt;
            r_pitch <= w_pitch_nxt;
            r_dv    <= (w_yaw_nxt != r_yaw) || (w_pitch_nxt != r_pitch);
        end
    end

endmodule

// File: tb/tb_servo_slew.sv
// Randomized bench for servo_slew against a behavioural model,
// plus directed scenarios with hand-computed expectations.
module tb_servo_slew;

    localparam int TD = 4;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] yaw_duty;
    logic [31:0] pitch_duty;
    logic        duty_valid;
    logic [1:0]  busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int dv_cnt = 0;

    servo_slew #(.TICK_DIV(TD)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .yaw_duty(yaw_duty), .pitch_duty(pitch_duty),
        .duty_valid(duty_valid), .busy(busy)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc++;
    always @(negedge PCLK) if (duty_valid) dv_cnt++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_ok = 0;
    logic [31:0] m_ty, m_tp, m_step, m_yaw, m_pitch, m_prdata;
    logic        m_en, m_snap, m_dv;
    int          m_en_cycles;

    function automatic bit is_mapped(input logic [7:0] a);
        return a inside {8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};
    endfunction

    function automatic logic [31:0] approach(input logic [31:0] cur,
                                             input logic [31:0] tgt,
                                             input logic [31:0] step);
        longint gap;
        longint mv;
        gap = longint'(tgt) - longint'(cur);
        mv = (gap < 0) ? -gap : gap;
        if (longint'(step) < mv) mv = longint'(step);
        return (gap < 0) ? 32'(longint'(cur) - mv) : 32'(longint'(cur) + mv);
    endfunction

    function automatic logic [31:0] clampv(input logic [31:0] v);
        if (v < 100000) return 32'd100000;
        if (v > 200000) return 32'd200000;
        return v;
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        logic [31:0] b;
        b = 0;
        b[8] = (m_yaw != m_ty);
        b[9] = (m_pitch != m_tp);
        b[0] = m_en;
        case (a)
            8'h00: return m_ty;
            8'h04: return m_tp;
            8'h08: return m_step;
            8'h0C: return b;
            8'h10: return m_yaw;
            8'h14: return m_pitch;
            default: return 0;
        endcase
    endfunction

    always @(posedge PCLK) begin
        logic [7:0]  a;
        logic [31:0] ny, np;
        bit          tk;
        a = PADDR[7:0];
        if (PRESET) begin
            m_ok = 1;
            m_ty = 150000; m_tp = 150000; m_step = 100;
            m_yaw = 150000; m_pitch = 150000;
            m_en = 1; m_snap = 0; m_dv = 0; m_prdata = 0;
            m_en_cycles = 0;
        end else if (m_ok) begin
            tk = m_en && (m_en_cycles % TD == TD - 1);
            ny = m_yaw; np = m_pitch;
            if (m_snap || (m_en && m_step == 0)) begin
                ny = m_ty; np = m_tp;
            end else if (tk) begin
                ny = approach(m_yaw, m_ty, m_step);
                np = approach(m_pitch, m_tp, m_step);
            end
            m_dv = (ny != m_yaw) || (np != m_pitch);
            if (PSEL && !PENABLE && !PWRITE) m_prdata = m_read(a);
            m_en_cycles = m_en ? m_en_cycles + 1 : 0;
            m_snap = 0;
            if (PSEL && PENABLE && PWRITE) begin
                case (a)
                    8'h00: m_ty = clampv(PWDATA);
                    8'h04: m_tp = clampv(PWDATA);
                    8'h08: m_step = PWDATA;
                    8'h0C: begin
                        m_en = PWDATA[0];
                        m_snap = PWDATA[1];
                    end
                    default: ;
                endcase
            end
            m_yaw = ny; m_pitch = np;
        end
    end

    // One compare process, every cycle once the model is live.
    always @(negedge PCLK) begin
        if (m_ok) begin
            chk("yaw_duty", yaw_duty, m_yaw);
            chk("pitch_duty", pitch_duty, m_pitch);
            chk("duty_valid", 32'(duty_valid), 32'(m_dv));
            chk("busy", 32'(busy), {30'd0, m_pitch != m_tp, m_yaw != m_ty});
            chk("PRDATA", PRDATA, m_prdata);
            chk("PSLVERR", 32'(PSLVERR),
                32'(PSEL && PENABLE && !is_mapped(PADDR[7:0])));
            chk("PREADY", 32'(PREADY), 32'd1);
        end
    end

    // ---------------- APB helpers ----------------
    task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1;
        @(posedge PCLK); #1;
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_rd(input logic [31:0] a, output logic [31:0] d,
                          output logic e);
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
        @(posedge PCLK); #1;
        PENABLE = 1;
        @(negedge PCLK);
        d = PRDATA; e = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 0; PENABLE = 0;
    endtask

    task automatic wait_yaw(input logic [31:0] v, output int at);
        at = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge PCLK);
            if (yaw_duty == v) begin
                at = cyc;
                break;
            end
        end
        total++;
        if (at < 0) begin
            bad++;
            $display("FAIL wait_yaw: timeout, yaw %0d want %0d", yaw_duty, v);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d, a, w;
        logic        e;
        int          t1, t2, t3, base;
        logic [31:0] frz;
        logic [7:0]  alist [8];
        alist = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h20};

        idle(3);
        PRESET = 0;
        idle(1);

        // 1: reset values
        apb_rd(32'h10, d, e); chk("t1 cur_yaw", d, 150000);
        apb_rd(32'h14, d, e); chk("t1 cur_pitch", d, 150000);
        apb_rd(32'h08, d, e); chk("t1 step", d, 100);
        chk("t1 busy", 32'(busy), 0);
        chk("t1 yaw_duty", yaw_duty, 150000);
        chk("t1 pitch_duty", pitch_duty, 150000);

        // 2: stepped slew
        apb_wr(32'h08, 1000);
        idle(2);
        base = dv_cnt;
        apb_wr(32'h00, 152500);
        wait_yaw(151000, t1);
        wait_yaw(152000, t2);
        wait_yaw(152500, t3);
        chk("t2 gap1", 32'(t2 - t1), TD);
        chk("t2 gap2", 32'(t3 - t2), TD);
        chk("t2 busy", 32'(busy), 0);
        idle(3);
        chk("t2 dv pulses", 32'(dv_cnt - base), 3);
        chk("t2 pitch", pitch_duty, 150000);

        // 3: clamp and unmapped
        apb_wr(32'h04, 50);
        apb_rd(32'h04, d, e); chk("t3 clamp lo", d, 100000);
        apb_wr(32'h04, 32'hFFFF_FFFF);
        apb_rd(32'h04, d, e); chk("t3 clamp hi", d, 200000);
        apb_rd(32'h20, d, e);
        chk("t3 unmapped err", 32'(e), 1);
        chk("t3 unmapped data", d, 0);
        apb_wr(32'h20, 32'h1234);
        apb_rd(32'h00, d, e); chk("t3 tgt_yaw kept", d, 152500);

        // 4: step 0 tracks immediately
        apb_wr(32'h08, 0);
        idle(4);
        base = dv_cnt;
        apb_wr(32'h00, 120000);
        @(negedge PCLK); chk("t4 yaw before", yaw_duty, 152500);
        @(negedge PCLK); chk("t4 yaw after", yaw_duty, 120000);
        idle(3);
        chk("t4 dv pulses", 32'(dv_cnt - base), 1);

        // 5: freeze then snap
        apb_wr(32'h08, 1000);
        apb_wr(32'h00, 180000);
        idle(10);
        apb_wr(32'h0C, 0);
        frz = m_yaw;
        chk("t5 mid-slew", 32'(frz > 120000 && frz < 180000), 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            chk("t5 frozen", yaw_duty, frz);
        end
        apb_wr(32'h0C, 2);
        @(negedge PCLK);
        @(negedge PCLK);
        chk("t5 snap yaw", yaw_duty, 180000);
        chk("t5 snap busy0", 32'(busy[0]), 0);
        apb_wr(32'h0C, 1);

        // 6: reset collides with a write
        apb_wr(32'h00, 100000);
        idle(10);
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h04; PWDATA = 123456;
        @(posedge PCLK); #1;
        PENABLE = 1; PRESET = 1;
        @(posedge PCLK); #1;
        PRESET = 0; PSEL = 0; PENABLE = 0; PWRITE = 0;
        chk("t6 yaw", yaw_duty, 150000);
        chk("t6 pitch", pitch_duty, 150000);
        apb_rd(32'h04, d, e); chk("t6 tgt_pitch", d, 150000);
        apb_rd(32'h08, d, e); chk("t6 step", d, 100);
        apb_rd(32'h0C, d, e); chk("t6 ctrl", d, 1);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            int op;
            op = $urandom_range(0, 9);
            a = {24'd0, alist[$urandom_range(0, 7)]};
            if ($urandom_range(0, 3) == 0) begin
                w = $urandom;
                a[31:8] = w[31:8];
            end
            case ($urandom_range(0, 2))
                0: d = $urandom_range(90000, 210000);
                1: d = $urandom_range(0, 20000);
                default: d = $urandom;
            endcase
            if (op <= 3) begin
                apb_wr(a, d);
            end else if (op <= 6) begin
                apb_rd(a, d, e);
            end else if (op == 7) begin
                idle($urandom_range(1, 8));
            end else if (op == 8) begin
                d = $urandom;
                d[0] = ($urandom_range(0, 3) != 0);
                apb_wr(32'h0C, d);
            end else if ($urandom_range(0, 3) == 0) begin
                @(posedge PCLK); #1;
                PRESET = 1;
                @(posedge PCLK); #1;
                PRESET = 0;
            end else begin
                idle(2);
            end
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
